// File: rtl/spi_real_if.sv
// Bus bundle for the write-only serial configuration port: serial data in, config state out.
// The controller side drives serial_in; the port side drives the config outputs.
interface spi_real_if;
    logic       serial_in;
    logic [7:0] load_cnt_ser;
    logic [2:0] select_reg;
    logic [7:0] trigger_channel_mask;
    logic [7:0] instruction;
    logic [7:0] mode;

    modport master (
        output serial_in,
        input  load_cnt_ser, select_reg, trigger_channel_mask, instruction, mode
    );

    modport slave (
        input  serial_in,
        output load_cnt_ser, select_reg, trigger_channel_mask, instruction, mode
    );
endinterface

// File: rtl/spi_real.sv
// Write-only serial config port: LSB-first bytes on sclk, first byte selects a register
// address, following bytes write config registers with address auto-increment.
module spi_real (
    input logic       sclk,
    input logic       rst,
    spi_real_if.slave bus
);
    typedef enum logic {S_ADDR, S_DATA} state_t;

    state_t     state, state_nxt;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt;
    logic [7:0] byte_val;
    logic       byte_done;

    logic [2:0] select_nxt;
    logic [7:0] cnt_nxt;
    logic [7:0] mask_nxt;
    logic [7:0] instr_nxt;
    logic [7:0] mode_nxt;

    // The byte completing on this edge includes the bit being sampled right now.
    assign byte_val  = {bus.serial_in, shift_q[7:1]};
    assign byte_done = (bit_cnt == 3'd7);

    always_comb begin
        state_nxt  = state;
        select_nxt = bus.select_reg;
        cnt_nxt    = bus.load_cnt_ser;
        mask_nxt   = bus.trigger_channel_mask;
        instr_nxt  = bus.instruction;
        mode_nxt   = bus.mode;
        if (byte_done) begin
            case (state)
                S_ADDR: begin
                    select_nxt = byte_val[2:0];
                    state_nxt  = S_DATA;
                end
                S_DATA: begin
                    // Addresses 0 and 4-7 have no register; the byte is still counted.
                    case (bus.select_reg)
                        3'd1:    mask_nxt  = byte_val;
                        3'd2:    instr_nxt = byte_val;
                        3'd3:    mode_nxt  = byte_val;
                        default: ;
                    endcase
                    select_nxt = bus.select_reg + 3'd1;
                    cnt_nxt    = bus.load_cnt_ser + 8'd1;
                end
                default: state_nxt = S_ADDR;
            endcase
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state                    <= S_ADDR;
            shift_q                  <= 8'd0;
            bit_cnt                  <= 3'd0;
            bus.select_reg           <= 3'd0;
            bus.load_cnt_ser         <= 8'd0;
            bus.trigger_channel_mask <= 8'd0;
            bus.instruction          <= 8'd0;
            bus.mode                 <= 8'd0;
        end else begin
            state                    <= state_nxt;
            shift_q                  <= byte_val;
            bit_cnt                  <= bit_cnt + 3'd1;
            bus.select_reg           <= select_nxt;
            bus.load_cnt_ser         <= cnt_nxt;
            bus.trigger_channel_mask <= mask_nxt;
            bus.instruction          <= instr_nxt;
            bus.mode                 <= mode_nxt;
        end
    end
endmodule

// File: tb/tb_spi_real.sv
// Directed bench for spi_real: LSB-first byte streams with hand-computed register results.
module tb_spi_real;
    logic sclk;
    logic rst;
    logic clk_en;
    int   checks;
    int   errors;

    spi_real_if bus ();

    spi_real dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    // Gated clock: held low while clk_en is 0 so the bench can pause mid-byte.
    initial sclk = 1'b0;
    always #5 sclk = clk_en ? ~sclk : 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] cnt, input logic [2:0] sel,
                             input logic [7:0] msk, input logic [7:0] ins, input logic [7:0] md);
        check({tag, ".load_cnt_ser"}, bus.load_cnt_ser, cnt);
        check({tag, ".select_reg"}, {5'd0, bus.select_reg}, {5'd0, sel});
        check({tag, ".trigger_channel_mask"}, bus.trigger_channel_mask, msk);
        check({tag, ".instruction"}, bus.instruction, ins);
        check({tag, ".mode"}, bus.mode, md);
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        @(posedge sclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge sclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        clk_en        = 1'b1;
        bus.serial_in = 1'b0;
        #1;
        check_all("reset", 8'h00, 3'd0, 8'h00, 8'h00, 8'h00);
        @(posedge sclk);
        #1;
        rst = 1'b0;

        // Scenario 1: partial byte then reset, then addr 1 + data A5
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset();
        check_all("s1_midreset", 8'h00, 3'd0, 8'h00, 8'h00, 8'h00);
        send_byte(8'h01);
        check("s1_addr.select_reg", {5'd0, bus.select_reg}, 8'h01);
        check("s1_addr.load_cnt_ser", bus.load_cnt_ser, 8'h00);
        send_byte(8'hA5);
        check_all("s1", 8'h01, 3'd2, 8'hA5, 8'h00, 8'h00);

        // Scenario 2: burst write to addresses 1,2,3
        do_reset();
        send_byte(8'h01);
        send_byte(8'h11);
        check_all("s2_b1", 8'h01, 3'd2, 8'h11, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        check_all("s2_midbyte", 8'h01, 3'd2, 8'h11, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        // 0x22 = bits 0,1,0,0,0,1,0,0; first nibble sent above is 0,1,0,1 -> redo cleanly
        do_reset();
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check_all("s2", 8'h03, 3'd4, 8'h11, 8'h22, 8'h33);

        // Scenario 6: async reset with no following sclk edge
        #2;
        rst = 1'b1;
        #1;
        check_all("s6_async", 8'h00, 3'd0, 8'h00, 8'h00, 8'h00);
        @(posedge sclk);
        #1;
        rst = 1'b0;

        // Scenario 3: address 7, two discarded bytes, select wraps 7->0->1
        send_byte(8'h07);
        send_byte(8'hFF);
        check_all("s3_b1", 8'h01, 3'd0, 8'h00, 8'h00, 8'h00);
        send_byte(8'hEE);
        check_all("s3", 8'h02, 3'd1, 8'h00, 8'h00, 8'h00);

        // Scenario 4: upper address bits ignored
        do_reset();
        send_byte(8'hFA);
        send_byte(8'h5C);
        check_all("s4", 8'h01, 3'd3, 8'h00, 8'h5C, 8'h00);

        // Scenario 5: clock paused mid-byte, then resumed
        do_reset();
        send_byte(8'h03);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        clk_en = 1'b0;
        #60;
        check_all("s5_paused", 8'h00, 3'd3, 8'h00, 8'h00, 8'h00);
        clk_en = 1'b1;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check_all("s5", 8'h01, 3'd4, 8'h00, 8'h00, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
